dtc_seq_walker: RTL
===================

# dtc_seq_walker

Sequential, table-driven decision-tree evaluator for the dt classifier flow. Accepts 9-bit feature vectors over a valid/ready stream and walks a node table one node per cycle from root to leaf. Emits the 1-bit class plus an error flag on an output stream. The node table is software-loaded through a configuration write port, so any split-0.5 tree (bm-series) runs without regenerating RTL.

## Interface
- N_FEAT, 9: feature vector width; feature index must be < N_FEAT
- ADDR_W, 7: node address width; table depth = 2**ADDR_W
- MAX_DEPTH, 16: maximum internal nodes visited before abort
- ENTRY_W, 20: fixed at 2 + 4 + 2*ADDR_W
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  sample valid
- in_data  in  N_FEAT  feature vector
- in_ready  out  1  high only in IDLE
- out_valid  out  1  result valid
- out_class  out  1  leaf class
- out_err  out  1  walk aborted (depth or bad feature index)
- out_ready  in  1  result consumed
- cfg_we  in  1  table write strobe
- cfg_addr  in  ADDR_W  entry address
- cfg_wdata  in  ENTRY_W  entry value
- cfg_ready  out  1  high only in IDLE; writes are applied only when cfg_we && cfg_ready

## Operation
- Entry layout: [0] leaf class, [1] is_leaf, [5:2] feature index, [5+ADDR_W:6] child_false, [5+2*ADDR_W:6+ADDR_W] child_true.
- Internal node: next = in_data[feat] ? child_true : child_false. Root is address 0.
- Table is a register array with combinational read. On reset, every entry is set to 'leaf, class 1' (value 3).
- States:
  - IDLE: in_ready=1, cfg_ready=1. On in_valid: latch in_data, node=0, depth=0, go to WALK.
  - WALK: read table[node].
    - Leaf: latch class, err=0, go to DONE.
    - Internal with feat >= N_FEAT: class=0, err=1, go to DONE.
    - Internal with depth == MAX_DEPTH: class=0, err=1, go to DONE.
    - Otherwise: node=next, depth+1.
  - DONE: out_valid=1. out_class and out_err are held stable. On out_ready, go to IDLE.
- Bad-index and depth checks apply only to internal nodes. A leaf at depth MAX_DEPTH is still a valid result.
- cfg_we outside IDLE is dropped silently, with no side effects. A write and a sample accept in the same IDLE cycle are both taken. The write lands at the clock edge, so the walk sees the new table.
- Depth counter is wide enough to hold MAX_DEPTH with no wrap.

## Timing
- Reset values: in_ready=1, cfg_ready=1, out_valid=0, out_class=0, out_err=0, state=IDLE, table all value 3.
- Latency: a sample accepted at edge T, with a path of d internal nodes, produces out_valid first high in cycle T+2+d.
  - Root leaf: T+2.
  - Abort: T+2+MAX_DEPTH at most.
- out_valid stays high, with data stable, until out_ready is sampled high. out_valid drops the next cycle and in_ready rises in that same cycle.
- Throughput: one result per 3+d cycles minimum. No overlap between samples.
- Reset mid-walk or in DONE: the result is lost, outputs return to reset values, and the table is reinitialised. There is no partial output.
- in_data is captured at accept. Changes on in_data afterwards do not affect the walk.

## Test plan
- Default table after reset. Send in_data=9'h1FF with out_ready=1 at accept T -> out_valid in T+2, class=1, err=0, in_ready high in T+3.
- Program the table as follows, then send in_data=9'h002 -> class 0 at T+3; in_data=9'h000 -> class 1 at T+3.
  - node0 = internal, feat 1, false->1, true->2
  - node1 = leaf 1
  - node2 = leaf 0
- Program node0 as internal, feat 0, both children 0 (a self-loop). Send any sample -> err=1, class=0, out_valid at T+2+16.
- Program node0 as internal with feat 9 -> err=1, class=0 at T+2.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid, out_class and out_err are stable. Any cfg_we in this window has no effect, confirmed by reading back via a later walk. in_valid pulses are not accepted.
- Assert rst during WALK of a depth-4 path -> out_valid=0, in_ready=1 after reset. The next sample returns class 1, since the table was reinitialised.

Source files
------------

// File: rtl/dtc_seq_walker.sv
// Sequential decision-tree walker: one node-table lookup per cycle from root to leaf.
// The node table is a software-loaded register array that reads combinationally.
module dtc_seq_walker #(
    parameter int N_FEAT    = 9,
    parameter int ADDR_W    = 7,
    parameter int MAX_DEPTH = 16,
    parameter int ENTRY_W   = 2 + 4 + 2*ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [N_FEAT-1:0]  in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic               out_class,
    output logic               out_err,
    input  logic               out_ready,
    input  logic               cfg_we,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [ENTRY_W-1:0] cfg_wdata,
    output logic               cfg_ready
);
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
    localparam int TBL_N   = 2**ADDR_W;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
    localparam logic [4:0]         FEAT_LIM  = 5'(N_FEAT);

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

    state_t               state, state_nxt;
    logic [ENTRY_W-1:0]   tbl [TBL_N];
    logic [N_FEAT-1:0]    data;
    logic [ADDR_W-1:0]    node;
    logic [DEPTH_W-1:0]   depth;
    logic                 cls_q, err_q;

    logic [ENTRY_W-1:0]   entry;
    logic                 is_leaf, leaf_cls, bad_feat, at_max, feat_bit;
    logic [3:0]           feat;
    logic [ADDR_W-1:0]    child_f, child_t;

    assign entry    = tbl[node];
    assign leaf_cls = entry[0];
    assign is_leaf  = entry[1];
    assign feat     = entry[5:2];
    assign child_f  = entry[5+ADDR_W:6];
    assign child_t  = entry[5+2*ADDR_W:6+ADDR_W];
    assign bad_feat = {1'b0, feat} >= FEAT_LIM;
    assign at_max   = depth == DEPTH_MAX;

    // Index select without reaching past the feature vector for out-of-range indices.
    always_comb begin
        feat_bit = 1'b0;
        for (int i = 0; i < N_FEAT; i++)
            if (feat == 4'(i)) feat_bit = data[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = WALK;
            WALK: if (is_leaf || bad_feat || at_max) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == IDLE;
        cfg_ready = state == IDLE;
        out_valid = state == DONE;
        out_class = cls_q;
        out_err   = err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            node  <= '0;
            depth <= '0;
            cls_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    data  <= in_data;
                    node  <= '0;
                    depth <= '0;
                end
                WALK: begin
                    // Leaf wins over the abort checks, so a leaf at MAX_DEPTH is a valid result.
                    if (is_leaf) begin
                        cls_q <= leaf_cls;
                        err_q <= 1'b0;
                    end else if (bad_feat || at_max) begin
                        cls_q <= 1'b0;
                        err_q <= 1'b1;
                    end else begin
                        node  <= feat_bit ? child_t : child_f;
                        depth <= depth + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TBL_N; i++) tbl[i] <= ENTRY_W'(3);
        end else if (cfg_we && state == IDLE) begin
            tbl[cfg_addr] <= cfg_wdata;
        end
    end
endmodule
